basic_gate_sweeper: RTL and testbench

//   Sequential stimulus and check stage around the two-input basic gate block.

---
 rtl/basic_gate_sweeper_if.sv | 30 +++
 rtl/basic_gate_sweeper.sv | 160 ++++++++++++++++
 tb/tb_basic_gate_sweeper.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/basic_gate_sweeper_if.sv
// Bundle between the gate sweeper and its neighbours: the start/busy/done request
// handshake and status on one side, and the gate block drive/result bus on the other.
interface basic_gate_sweeper_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] err_mask;
  logic [7:0] err_count;
  logic [1:0] first_err_vec;
  logic       drv_in1;
  logic       drv_in2;
  logic       and_out;
  logic       or_out;
  logic       not_out;
  logic       nand_out;
  logic       nor_out;
  logic       xor_out;
  logic       xnor_out;

  modport master (
    output start, and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out,
    input  busy, done, pass, err_mask, err_count, first_err_vec, drv_in1, drv_in2
  );

  modport slave (
    input  start, and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out,
    output busy, done, pass, err_mask, err_count, first_err_vec, drv_in1, drv_in2
  );
endinterface

// File: rtl/basic_gate_sweeper.sv
// Sweeps the two-input gate block through all four input vectors REPEAT times,
// checks the seven gate results against golden values and reports a pass/fail summary.
module basic_gate_sweeper #(
  parameter int SETTLE_CYCLES = 1,
  parameter int REPEAT        = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  basic_gate_sweeper_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_e;

  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam int RW = $clog2(REPEAT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  localparam logic [RW-1:0] SWEEP_LAST  = RW'(REPEAT - 1);

  state_e          state_q, state_d;
  logic [1:0]      vec_q, vec_d;
  logic [RW-1:0]   sweep_q, sweep_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [1:0]      drv_q, drv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [6:0]      err_mask_q, err_mask_d;
  logic [7:0]      err_count_q, err_count_d;
  logic [1:0]      first_err_vec_q, first_err_vec_d;
  logic            err_seen_q, err_seen_d;
  logic            start_prev_q, start_prev_d;

  logic            start_rise;
  logic            last_sample;
  logic            a, b;
  logic [6:0]      golden;
  logic [6:0]      observed;
  logic [6:0]      mismatch;

  // A request is its rising edge, so a start level held high launches only one sweep.
  assign start_rise  = bus.start & ~start_prev_q;
  assign last_sample = (vec_q == 2'd3) && (sweep_q == SWEEP_LAST);
  assign a           = vec_q[1];
  assign b           = vec_q[0];
  assign golden      = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign observed    = {bus.xnor_out, bus.xor_out, bus.nor_out, bus.nand_out,
                        bus.not_out, bus.or_out, bus.and_out};
  assign mismatch    = observed ^ golden;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      vec_q           <= '0;
      sweep_q         <= '0;
      settle_q        <= '0;
      drv_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_mask_q      <= '0;
      err_count_q     <= '0;
      first_err_vec_q <= '0;
      err_seen_q      <= 1'b0;
      start_prev_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      vec_q           <= vec_d;
      sweep_q         <= sweep_d;
      settle_q        <= settle_d;
      drv_q           <= drv_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      err_mask_q      <= err_mask_d;
      err_count_q     <= err_count_d;
      first_err_vec_q <= first_err_vec_d;
      err_seen_q      <= err_seen_d;
      start_prev_q    <= start_prev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_rise) state_d = DRIVE;
      DRIVE:   state_d = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
      SETTLE:  if (settle_q == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:  state_d = last_sample ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_d           = vec_q;
    sweep_d         = sweep_q;
    settle_d        = settle_q;
    drv_d           = drv_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    pass_d          = pass_q;
    err_mask_d      = err_mask_q;
    err_count_d     = err_count_q;
    first_err_vec_d = first_err_vec_q;
    err_seen_d      = err_seen_q;
    start_prev_d    = bus.start;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          vec_d           = '0;
          sweep_d         = '0;
          busy_d          = 1'b1;
          pass_d          = 1'b0;
          err_mask_d      = '0;
          err_count_d     = '0;
          first_err_vec_d = '0;
          err_seen_d      = 1'b0;
        end
      end
      DRIVE: begin
        drv_d    = vec_q;
        settle_d = '0;
      end
      SETTLE: settle_d = settle_q + SW'(1);
      SAMPLE: begin
        // One count per mismatching vector, however many of its seven bits differ.
        if (|mismatch) begin
          err_mask_d  = err_mask_q | mismatch;
          err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
          if (!err_seen_q) begin
            first_err_vec_d = vec_q;
            err_seen_d      = 1'b1;
          end
        end
        if (!last_sample) begin
          vec_d = vec_q + 2'd1;
          if (vec_q == 2'd3) sweep_d = sweep_q + RW'(1);
        end
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        pass_d = (err_count_q == 8'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.drv_in1       = drv_q[1];
    bus.drv_in2       = drv_q[0];
    bus.busy          = busy_q;
    bus.done          = done_q;
    bus.pass          = pass_q;
    bus.err_mask      = err_mask_q;
    bus.err_count     = err_count_q;
    bus.first_err_vec = first_err_vec_q;
  end

endmodule

// File: tb/tb_basic_gate_sweeper.sv
// Scoreboard bench for basic_gate_sweeper: three instances with different SETTLE/REPEAT
// share one start and one gate-fault table; a per-instance monitor checks each done pulse.
module tb_basic_gate_sweeper;

  localparam int S0 = 1, R0 = 1;
  localparam int S1 = 0, R1 = 2;
  localparam int S2 = 0, R2 = 100;

  typedef struct {
    logic [6:0] mask;
    logic [7:0] count;
    logic [1:0] first;
    logic       pass;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_r;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic [6:0] flip_tab [4];
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  basic_gate_sweeper_if bus0();
  basic_gate_sweeper_if bus1();
  basic_gate_sweeper_if bus2();

  // Ideal gate truth table, bit order {xnor,xor,nor,nand,not,or,and}.
  function automatic logic [6:0] gate_ref(input logic x, input logic y);
    return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~x, x | y, x & y};
  endfunction

  // Gate block model: ideal result with the per-vector fault bits of flip_tab applied.
  assign bus0.start = start_r;
  assign bus1.start = start_r;
  assign bus2.start = start_r;
  assign {bus0.xnor_out, bus0.xor_out, bus0.nor_out, bus0.nand_out, bus0.not_out, bus0.or_out, bus0.and_out} =
         gate_ref(bus0.drv_in1, bus0.drv_in2) ^ flip_tab[{bus0.drv_in1, bus0.drv_in2}];
  assign {bus1.xnor_out, bus1.xor_out, bus1.nor_out, bus1.nand_out, bus1.not_out, bus1.or_out, bus1.and_out} =
         gate_ref(bus1.drv_in1, bus1.drv_in2) ^ flip_tab[{bus1.drv_in1, bus1.drv_in2}];
  assign {bus2.xnor_out, bus2.xor_out, bus2.nor_out, bus2.nand_out, bus2.not_out, bus2.or_out, bus2.and_out} =
         gate_ref(bus2.drv_in1, bus2.drv_in2) ^ flip_tab[{bus2.drv_in1, bus2.drv_in2}];

  basic_gate_sweeper #(.SETTLE_CYCLES(S0), .REPEAT(R0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  basic_gate_sweeper #(.SETTLE_CYCLES(S1), .REPEAT(R1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  basic_gate_sweeper #(.SETTLE_CYCLES(S2), .REPEAT(R2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic checkOutput(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic spurious_done(input int id);
    tests++;
    fails++;
    $display("[TB] FAIL spurious_done dut%0d: got done=1 expected done=0 (no sweep outstanding)", id);
  endtask

  // Result of one start, from the fault table alone: every faulty vector miscompares once per sweep.
  function automatic exp_t model(input int rep, input int settle, input int now);
    exp_t e;
    int   bad = 0;
    int   total;
    bit   found = 0;
    e.mask  = '0;
    e.first = '0;
    for (int v = 0; v < 4; v++) begin
      if (flip_tab[v] != 7'd0) begin
        bad++;
        e.mask |= flip_tab[v];
        if (!found) begin
          e.first = 2'(v);
          found   = 1;
        end
      end
    end
    total   = bad * rep;
    e.count = (total > 255) ? 8'd255 : 8'(total);
    e.pass  = (total == 0);
    e.cyc   = now + 2 + 4 * rep * (settle + 2);
    return e;
  endfunction

  task automatic check_done(input int id, input exp_t e, input logic [6:0] m, input logic [7:0] c,
                            input logic [1:0] f, input logic p, input logic b, input logic [1:0] d);
    checkOutput("done_cycle", id, cyc, e.cyc);
    checkOutput("err_mask", id, 32'(m), 32'(e.mask));
    checkOutput("err_count", id, 32'(c), 32'(e.count));
    checkOutput("first_err_vec", id, 32'(f), 32'(e.first));
    checkOutput("pass", id, 32'(p), 32'(e.pass));
    checkOutput("busy_at_done", id, 32'(b), 32'd0);
    checkOutput("drv_last_vec", id, 32'(d), 32'd3);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus0.done === 1'b1) begin
      if (q0.size() == 0) spurious_done(0);
      else check_done(0, q0.pop_front(), bus0.err_mask, bus0.err_count, bus0.first_err_vec,
                      bus0.pass, bus0.busy, {bus0.drv_in1, bus0.drv_in2});
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus1.done === 1'b1) begin
      if (q1.size() == 0) spurious_done(1);
      else check_done(1, q1.pop_front(), bus1.err_mask, bus1.err_count, bus1.first_err_vec,
                      bus1.pass, bus1.busy, {bus1.drv_in1, bus1.drv_in2});
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus2.done === 1'b1) begin
      if (q2.size() == 0) spurious_done(2);
      else check_done(2, q2.pop_front(), bus2.err_mask, bus2.err_count, bus2.first_err_vec,
                      bus2.pass, bus2.busy, {bus2.drv_in1, bus2.drv_in2});
    end
  end

  task automatic set_flips(input logic [6:0] f0, input logic [6:0] f1, input logic [6:0] f2, input logic [6:0] f3);
    flip_tab[0] = f0;
    flip_tab[1] = f1;
    flip_tab[2] = f2;
    flip_tab[3] = f3;
  endtask

  task automatic check_all_zero();
    checkOutput("outputs_zero", 0, 32'({bus0.drv_in1, bus0.drv_in2, bus0.busy, bus0.done, bus0.pass,
                bus0.err_mask, bus0.err_count, bus0.first_err_vec}), 32'd0);
    checkOutput("outputs_zero", 1, 32'({bus1.drv_in1, bus1.drv_in2, bus1.busy, bus1.done, bus1.pass,
                bus1.err_mask, bus1.err_count, bus1.first_err_vec}), 32'd0);
    checkOutput("outputs_zero", 2, 32'({bus2.drv_in1, bus2.drv_in2, bus2.busy, bus2.done, bus2.pass,
                bus2.err_mask, bus2.err_count, bus2.first_err_vec}), 32'd0);
  endtask

  // Raises start for 'hold' rising edges and queues one expected result per instance.
  task automatic applyStimulus(input int hold);
    @(negedge clk);
    q0.push_back(model(R0, S0, cyc));
    q1.push_back(model(R1, S1, cyc));
    q2.push_back(model(R2, S2, cyc));
    start_r = 1'b1;
    @(negedge clk);
    checkOutput("busy_after_start", 0, 32'(bus0.busy), 32'd1);
    checkOutput("busy_after_start", 1, 32'(bus1.busy), 32'd1);
    checkOutput("busy_after_start", 2, 32'(bus2.busy), 32'd1);
    repeat (hold - 1) @(negedge clk);
    start_r = 1'b0;
  endtask

  task automatic wait_all(input int budget);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL done_timeout: got %0d/%0d/%0d results outstanding expected 0/0/0",
               q0.size(), q1.size(), q2.size());
      q0.delete();
      q1.delete();
      q2.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_r = 1'b0;
    set_flips(7'd0, 7'd0, 7'd0, 7'd0);
    #1;
    check_all_zero();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Fault-free gate, then AND stuck at 0, XOR tied to XNOR, and every output inverted.
    applyStimulus(1);
    wait_all(2000);
    set_flips(7'h00, 7'h00, 7'h00, 7'h01);
    applyStimulus(1);
    wait_all(2000);
    set_flips(7'h20, 7'h20, 7'h20, 7'h20);
    applyStimulus(1);
    wait_all(2000);
    set_flips(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    applyStimulus(1);
    wait_all(2000);

    // A start level held for 20 cycles must give exactly one sweep per instance.
    set_flips(7'd0, 7'd0, 7'd0, 7'd0);
    applyStimulus(20);
    wait_all(2000);

    // Random fault tables with an extra start pulse while busy, which must be ignored.
    for (int i = 0; i < 6; i++) begin
      for (int v = 0; v < 4; v++)
        flip_tab[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      applyStimulus(1);
      repeat ($urandom_range(1, 8)) @(negedge clk);
      start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      wait_all(2000);
    end

    // Reset while the first instance settles vector 2: everything clears, no done follows.
    set_flips(7'h00, 7'h04, 7'h00, 7'h00);
    applyStimulus(1);
    repeat (7) @(negedge clk);
    q0.delete();
    q1.delete();
    q2.delete();
    rst_n = 1'b0;
    #1;
    check_all_zero();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    set_flips(7'd0, 7'd0, 7'd0, 7'd0);
    applyStimulus(1);
    wait_all(2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
